// File: rtl/imem_arbiter_pkg.sv
// Shared types, defaults and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

  typedef enum logic {
    StIdle,
    StIssue
  } state_t;

  typedef enum logic {
    OwnF,
    OwnD
  } owner_t;

  localparam int unsigned StarveMaxDefault = 4;
  localparam int unsigned StarveCntW       = 4;

  function automatic logic [StarveCntW-1:0] sat_inc(input logic [StarveCntW-1:0] v,
                                                     input logic [StarveCntW-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/imem_arb_prio.sv
// Fixed fetch priority with a starvation counter that eventually forces a debug win.
module imem_arb_prio
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f_req,
  input  logic d_req,
  input  logic f_flush,
  input  logic window,
  output logic f_sel,
  output logic d_sel
);

  localparam logic [StarveCntW-1:0] Lim = StarveCntW'(STARVE_MAX);

  logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
  logic                  starved;

  always_comb begin
    starved = (starve_cnt_q == Lim);
    d_sel   = window & d_req & (~f_req | f_flush | starved);
    f_sel   = window & ~d_sel & f_req & ~f_flush;
  end

  // Counts fetch wins only while debug is actually waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_sel || !d_req) begin
      starve_cnt_d = '0;
    end else if (f_sel) begin
      starve_cnt_d = sat_inc(starve_cnt_q, Lim);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-ported instruction memory between fetch and debug read ports,
// one access in flight, with responses returned as one-cycle valid pulses.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_instr,
  input  logic              mem_ready,
  output logic              busy
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              kill_q, kill_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              window, done, grant;
  logic              f_sel, d_sel;

  // ready is only meaningful while an access is outstanding.
  assign done   = (state_q == StIssue) & mem_ready;
  assign window = (state_q == StIdle) | done;

  imem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .d_req   (d_req),
    .f_flush (f_flush),
    .window  (window),
    .f_sel   (f_sel),
    .d_sel   (d_sel)
  );

  assign f_gnt = f_sel & rst_n;
  assign d_gnt = d_sel & rst_n;
  assign grant = f_gnt | d_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: if (mem_ready && !grant) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == StIssue);
    busy      = (state_q == StIssue);
    mem_addr  = addr_q;
    f_rvalid  = f_rvalid_q;
    d_rvalid  = d_rvalid_q;
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
  end

  always_comb begin
    addr_d     = addr_q;
    owner_d    = owner_q;
    kill_d     = kill_q;
    f_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;

    if (done) begin
      if (owner_q == OwnF) begin
        // A flush now or at any point since the grant drops the fetch response.
        if (!kill_q && !f_flush) begin
          f_rvalid_d = 1'b1;
          f_rdata_d  = mem_instr;
        end
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_instr;
      end
    end

    if ((state_q == StIssue) && (owner_q == OwnF) && f_flush) begin
      kill_d = 1'b1;
    end

    if (grant) begin
      addr_d  = d_gnt ? d_addr : f_addr;
      owner_d = d_gnt ? OwnD : OwnF;
      kill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      owner_q    <= OwnF;
      kill_q     <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Structural invariants of the arbiter.
  gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(f_gnt && d_gnt));
  rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(f_rvalid && d_rvalid));
  wait_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                (busy && !mem_ready) |=> (busy && $stable(mem_addr)));

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter with a queue-based scoreboard.
module tb_imem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int         SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic          f_gnt, d_gnt, f_rvalid, d_rvalid, mem_rd_en, busy;
  logic [DW-1:0] f_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_instr = '0;
  logic          mem_ready = 1'b0;
  logic          was_rd = 1'b0;
  bit            stall_force = 1'b0, rand_stall = 1'b0;

  int checks = 0, failures = 0, cyc = 0;
  int rd_run = 0, rd_max = 0, f_deliv = 0, d_deliv = 0;
  bit f_acc = 1'b0, d_acc = 1'b0;

  typedef struct {
    bit          is_f;
    logic [31:0] addr;
    bit          killed;
    bit          done;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  imem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_flush   (f_flush),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory: latches on negedge; ready may linger one negedge after rd_en drops.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (stall_force || (rand_stall && $urandom_range(0, 3) == 0)) begin
        mem_ready <= 1'b0;
        mem_instr <= $urandom;
      end else begin
        mem_ready <= 1'b1;
        mem_instr <= mem_word(mem_addr);
      end
      was_rd <= 1'b1;
    end else begin
      mem_ready <= mem_ready && was_rd;
      was_rd    <= 1'b0;
    end
  end

  // Reference model: predicts grants and pushes expected responses.
  bit          m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  int          streak = 0;
  bit          open_w, ed, ef;
  exp_t        e;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    rd_run = mem_rd_en ? rd_run + 1 : 0;
    if (rd_run > rd_max) rd_max = rd_run;
    if (!rst_n) begin
      chk("gnt_in_reset", 64'({f_gnt, d_gnt}), 64'd0);
      chk("rd_en_in_reset", 64'(mem_rd_en), 64'd0);
      m_busy = 1'b0;
      streak = 0;
      exp_q.delete();
      f_acc = 1'b0;
      d_acc = 1'b0;
    end else begin
      chk("rd_en", 64'(mem_rd_en), 64'(m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      if (m_busy) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      open_w = !m_busy || mem_ready;
      ed = open_w && d_req && (!f_req || f_flush || streak == SM);
      ef = open_w && !ed && f_req && !f_flush;
      chk("f_gnt", 64'(f_gnt), 64'(ef));
      chk("d_gnt", 64'(d_gnt), 64'(ed));
      if (m_busy && exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        if (e.is_f && f_flush) e.killed = 1'b1;
        if (mem_ready) begin
          e.done = 1'b1;
          e.due  = cyc + 1;
          m_busy = 1'b0;
        end
        exp_q[exp_q.size()-1] = e;
      end
      if (ed || ef) begin
        e.is_f   = ef;
        e.addr   = ed ? d_addr : f_addr;
        e.killed = 1'b0;
        e.done   = 1'b0;
        e.due    = 0;
        exp_q.push_back(e);
        m_busy = 1'b1;
        m_addr = e.addr;
      end
      if (!d_req || ed) streak = 0;
      else if (ef && streak < SM) streak++;
      f_acc = f_gnt;
      d_acc = d_gnt;
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  exp_t        em;
  logic [31:0] last_f = '0, last_d = '0;

  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      chk("rvalid_in_reset", 64'({f_rvalid, d_rvalid}), 64'd0);
      chk("rdata_in_reset", 64'({f_rdata, d_rdata}), 64'd0);
      last_f = '0;
      last_d = '0;
    end else begin
      chk("one_rvalid", 64'(f_rvalid & d_rvalid), 64'd0);
      while (exp_q.size() > 0 && exp_q[0].killed && exp_q[0].done && exp_q[0].due <= cyc)
        exp_q.delete(0);
      if (f_rvalid || d_rvalid) begin
        if (exp_q.size() == 0 || !exp_q[0].done) begin
          chk("unexpected_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
        end else begin
          em = exp_q[0];
          exp_q.delete(0);
          chk("rvalid_port", 64'(f_rvalid), 64'(em.is_f));
          chk("rvalid_cycle", 64'(cyc), 64'(em.due));
          if (em.is_f) begin
            chk("f_rdata", 64'(f_rdata), 64'(mem_word(em.addr)));
            last_f = mem_word(em.addr);
          end else begin
            chk("d_rdata", 64'(d_rdata), 64'(mem_word(em.addr)));
            last_d = mem_word(em.addr);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].done && exp_q[0].due <= cyc) begin
        chk("missing_rvalid", 64'(f_rvalid | d_rvalid), 64'd1);
        exp_q.delete(0);
      end
      if (!f_rvalid) chk("f_rdata_hold", 64'(f_rdata), 64'(last_f));
      if (!d_rvalid) chk("d_rdata_hold", 64'(d_rdata), 64'(last_d));
      if (f_rvalid) f_deliv++;
      if (d_rvalid) d_deliv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input bit port_f, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(port_f ? f_acc : d_acc) && n < 40);
    chk(name, 64'(port_f ? f_acc : d_acc), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nf, nd, guard, base, pend;
    repeat (3) tick();
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch.
    f_addr = 32'h10;
    f_req  = 1'b1;
    wait_acc(1'b1, "single_gnt");
    f_req = 1'b0;
    chk("single_rd_en", 64'(mem_rd_en), 64'd1);
    tick();
    chk("single_rvalid", 64'(f_rvalid), 64'd1);
    chk("single_data", 64'(f_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("single_idle", 64'(busy), 64'd0);
    repeat (3) tick();

    // Streaming fetch 0..7.
    rd_max = 0;
    f_addr = 32'h0;
    f_req  = 1'b1;
    n      = 0;
    guard  = 0;
    while (n < 8 && guard < 100) begin
      tick();
      guard++;
      if (f_acc) begin
        n++;
        f_addr = 32'(n);
      end
    end
    f_req = 1'b0;
    repeat (4) tick();
    chk("stream_grants", 64'(n), 64'd8);
    chk("stream_rd_run", 64'(rd_max), 64'd8);

    // Starvation.
    nf = 0;
    nd = 0;
    guard  = 0;
    f_addr = 32'd100;
    d_addr = 32'd200;
    f_req  = 1'b1;
    d_req  = 1'b1;
    while (nf + nd < 20 && guard < 100) begin
      tick();
      guard++;
      if (f_acc) begin
        nf++;
        f_addr = f_addr + 1;
      end
      if (d_acc) begin
        nd++;
        d_addr = d_addr + 1;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (4) tick();
    chk("starve_d_grants", 64'(nd), 64'd4);
    chk("starve_f_grants", 64'(nf), 64'd16);

    // Flush of an in-flight fetch.
    base   = f_deliv;
    f_addr = 32'h20;
    f_req  = 1'b1;
    wait_acc(1'b1, "flush_gnt");
    f_flush = 1'b1;
    f_addr  = 32'h24;
    tick();
    chk("flush_blocks_gnt", 64'(f_acc), 64'd0);
    f_flush = 1'b0;
    wait_acc(1'b1, "flush_next_gnt");
    f_req = 1'b0;
    repeat (4) tick();
    chk("flush_deliv", 64'(f_deliv - base), 64'd1);

    // Wait states.
    f_addr = 32'h30;
    f_req  = 1'b1;
    wait_acc(1'b1, "wait_gnt");
    f_req       = 1'b0;
    stall_force = 1'b1;
    d_addr      = 32'h50;
    d_req       = 1'b1;
    tick();
    chk("wait_no_gnt1", 64'(d_acc), 64'd0);
    tick();
    chk("wait_no_gnt2", 64'(d_acc), 64'd0);
    stall_force = 1'b0;
    wait_acc(1'b0, "wait_d_gnt");
    d_req = 1'b0;
    chk("wait_rvalid", 64'(f_rvalid), 64'd1);
    chk("wait_data", 64'(f_rdata), 64'(mem_word(32'h30)));
    repeat (4) tick();

    // Reset during a debug access.
    base   = d_deliv;
    d_addr = 32'h44;
    d_req  = 1'b1;
    wait_acc(1'b0, "rst_gnt");
    d_addr = 32'h48;
    rst_n  = 1'b0;
    #1;
    chk("rstmid_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_gnt", 64'({f_gnt, d_gnt}), 64'd0);
    chk("rstmid_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
    chk("rstmid_rdata", 64'({f_rdata, d_rdata}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_acc(1'b0, "post_rst_gnt");
    d_req = 1'b0;
    repeat (4) tick();
    chk("rst_deliv", 64'(d_deliv - base), 64'd1);

    // Random traffic with random wait states.
    rand_stall = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!f_req || f_acc) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = 32'($urandom_range(0, 255));
      end
      if (!d_req || d_acc) begin
        d_req  = ($urandom_range(0, 2) == 0);
        d_addr = $urandom;
      end
      f_flush = ($urandom_range(0, 9) == 0);
    end
    f_req      = 1'b0;
    d_req      = 1'b0;
    f_flush    = 1'b0;
    rand_stall = 1'b0;
    repeat (8) tick();
    pend = 0;
    foreach (exp_q[i]) if (!exp_q[i].killed) pend++;
    chk("drain_empty", 64'(pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
